// File: rtl/button_cond_pkg.sv
// Shared constants and helpers for the push-button conditioner.
package button_cond_pkg;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

  // 10 ms hold time at a 50 MHz clock
  localparam int DEBOUNCE_10MS_50MHZ = 500000;

  // Smallest width w (at least 1) with 2**w >= value
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, counter debounce, edge pulses and an
// ack-cleared sticky event flag.
module button_channel
  import button_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int CNT_W           = clog2(DEBOUNCE_CYCLES),
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  input  logic edge_sel,
  input  logic ack,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic event_flag
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic s, differ, accept, rise_next, fall_next, sel_edge;

  assign s         = sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign differ    = (s != level);
  assign accept    = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise_next = accept & s;
  assign fall_next = accept & ~s;
  assign sel_edge  = (edge_sel == EDGE_FALL) ? fall_next : rise_next;

  // Sync flops reset to the released pin value so reset release is not seen as a press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync       <= {SYNC_STAGES{ACTIVE_LOW}};
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      event_flag <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_raw};
      if (accept) begin
        level <= s;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      // a new edge outranks an ack on the same cycle
      event_flag <= sel_edge | (event_flag & ~ack);
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner; one button_channel per pin plus
// a combined event indication.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int CNT_W           = clog2(DEBOUNCE_CYCLES),
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] edge_sel,
  input  logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] event_flag,
  output logic            any_event
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if ((1 << CNT_W) < DEBOUNCE_CYCLES) begin : g_bad_cnt
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .btn_raw   (btn_raw[g]),
      .edge_sel  (edge_sel[g]),
      .ack       (ack[g]),
      .level     (level[g]),
      .rise_pulse(rise_pulse[g]),
      .fall_pulse(fall_pulse[g]),
      .event_flag(event_flag[g])
    );
  end

  // flags are already registered, so the OR adds no latency
  assign any_event = |event_flag;

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner with an expected-value queue.
module tb_button_conditioner;
  import button_cond_pkg::*;

  localparam int N_CH = 2, SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, CNT_W = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N_CH-1:0] btn_raw, edge_sel, ack;
  logic [N_CH-1:0] level, rise_pulse, fall_pulse, event_flag;
  logic any_event;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;

  typedef struct {
    string name;
    logic [1:0] raw, esel, ack_v, lvl, rise, fall, flag;
  } vec_t;
  typedef struct {
    string name;
    logic [1:0] lvl, rise, fall, flag;
    logic any;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  button_conditioner #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W), .ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .edge_sel(edge_sel), .ack(ack),
    .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_flag(event_flag), .any_event(any_event)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input int n, input string name, input logic [1:0] raw, esel, a,
                     lvl, rise, fall, flag);
    vec_t v;
    v.name = name; v.raw = raw; v.esel = esel; v.ack_v = a;
    v.lvl = lvl; v.rise = rise; v.fall = fall; v.flag = flag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // drive one cycle, queue its expectation, then compare after the edge
  task automatic step(input string name, input logic [1:0] raw, esel, a,
                      lvl, rise, fall, flag);
    exp_t e;
    btn_raw = raw; edge_sel = esel; ack = a;
    e.name = name; e.lvl = lvl; e.rise = rise; e.fall = fall; e.flag = flag;
    e.any = |flag;
    exp_q.push_back(e);
    @(posedge clock); #1;
    e = exp_q.pop_front();
    chk({e.name, ".level"}, level, e.lvl);
    chk({e.name, ".rise"}, rise_pulse, e.rise);
    chk({e.name, ".fall"}, fall_pulse, e.fall);
    chk({e.name, ".flag"}, event_flag, e.flag);
    chk({e.name, ".any"}, {1'b0, any_event}, {1'b0, e.any});
    chk({e.name, ".excl"}, rise_pulse & fall_pulse, 2'b00);
    if (rise_pulse[0]) rise_cnt++;
  endtask

  initial begin
    btn_raw = 2'b11; edge_sel = 2'b00; ack = 2'b00;

    // clean press / release on channel 0
    add(5, "press",      2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "press_acc",  2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(2, "press_hold", 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1, "ack0",       2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, "ack_idle",   2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(5, "rel",        2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, "rel_acc",    2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(1, "rel_after",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // 3-cycle glitch rejected, then a minimal 4-cycle press accepted
    add(3, "glitch_low", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4, "glitch_hi",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4, "min_low",    2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "min_high",   2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "min_acc",    2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(3, "min_hold",   2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1, "min_rel",    2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    add(1, "min_ack",    2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    // channel 1 flags on release; edge_sel change keeps the set flag
    add(5, "c1_press",   2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "c1_rise",    2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);
    add(1, "c1_hold",    2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(5, "c1_rel",     2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(1, "c1_fall",    2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10);
    add(2, "c1_sticky",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    add(1, "c1_ack",     2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    // ack on the accepting edge: set wins, next ack clears
    add(5, "col_press",  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "col_set",    2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01);
    add(1, "col_ack",    2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, "col_idle",   2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(5, "col_rel",    2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, "col_fall",   2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    // both channels together, partial ack
    add(5, "both_press", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "both_rise",  2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11);
    add(1, "both_ack0",  2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10);
    add(1, "both_idle",  2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10);
    add(1, "both_ack1",  2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    add(5, "both_rel",   2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, "both_fall",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(1, "idle",       2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset.level", level, 2'b00);
    chk("reset.flag", event_flag, 2'b00);
    chk("reset.pulses", rise_pulse | fall_pulse, 2'b00);
    chk("reset.any", {1'b0, any_event}, 2'b00);
    reset = 1'b0;

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].raw, vecs[i].esel, vecs[i].ack_v,
           vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].flag);

    // reset mid-debounce with the button held through it
    repeat (3) step("rst_pre", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset = 1'b1;
    repeat (2) step("rst_hold", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    rise_cnt = 0;
    repeat (5) step("rst_wait", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step("rst_rise", 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    repeat (3) step("rst_keep", 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    checks++;
    if (rise_cnt != 1) begin
      errors++;
      $display("FAIL rst_one_rise: got %0d pulses expected 1", rise_cnt);
    end

    // reset asserted during a fall pulse clears everything at once
    repeat (5) step("rst_rel", 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    step("rst_fall", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    reset = 1'b1;
    #1;
    chk("async.fall", fall_pulse, 2'b00);
    chk("async.flag", event_flag, 2'b00);
    chk("async.any", {1'b0, any_event}, 2'b00);
    step("rst_in", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    repeat (3) step("rst_post", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
